// File: rtl/mux2_32.sv
// mux2_32: two-input word selector for the MIPS datapath (ALUSrc, MemtoReg,
// RegDst, PC-source) with an optional registered copy for pipeline use.
//
// Ports:
//   in1       [WIDTH] data selected when select = 0
//   in2       [WIDTH] data selected when select = 1
//   out       [WIDTH] combinational selection (zero-cycle latency)
//   select    [1]     0 -> in1, 1 -> in2
//   clk       [1]     rising-edge clock, registered path only
//   reset     [1]     synchronous active-high reset of the registered path
//   en        [1]     load strobe for out_q
//   out_q     [WIDTH] registered selection (one-cycle latency)
//   out_valid [1]     out_q holds data loaded since the last reset
module mux2_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  input  logic             select,
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  // Combinational selection; X on select is left to propagate naturally.
  assign out = select ? in2 : in1;

  // Next-state for the output register: load on en, otherwise hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      data_d  = out;
      valid_d = 1'b1;
    end
  end

  // Synchronous reset takes priority over a simultaneous load.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_q     = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux2_32.sv
// Directed bench for mux2_32: combinational vector table plus hand-written
// sequences for reset, load, hold and a narrow-width instance.
module tb_mux2_32;

  logic [31:0] in1, in2, out, out_q;
  logic        select, clk, reset, en, out_valid;

  logic [4:0]  n_in1, n_in2, n_out, n_out_q;
  logic        n_select, n_en, n_valid;

  int n_vec;
  int n_bad;

  mux2_32 #(.WIDTH(32)) dut (
    .in1(in1), .in2(in2), .out(out), .select(select),
    .clk(clk), .reset(reset), .en(en),
    .out_q(out_q), .out_valid(out_valid)
  );

  mux2_32 #(.WIDTH(5)) dut5 (
    .in1(n_in1), .in2(n_in2), .out(n_out), .select(n_select),
    .clk(clk), .reset(reset), .en(n_en),
    .out_q(n_out_q), .out_valid(n_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    in1 = '0; in2 = '0; select = 1'b0; reset = 1'b0; en = 1'b0;
    n_in1 = '0; n_in2 = '0; n_select = 1'b0; n_en = 1'b0;

    // Sweep of {in1[0], in2[1], select} = 0..7, then full-word selects.
    vecs[0] = '{"sweep0", 32'd0, 32'd0, 1'b0, 32'd0};
    vecs[1] = '{"sweep1", 32'd0, 32'd0, 1'b1, 32'd0};
    vecs[2] = '{"sweep2", 32'd0, 32'd2, 1'b0, 32'd0};
    vecs[3] = '{"sweep3", 32'd0, 32'd2, 1'b1, 32'd2};
    vecs[4] = '{"sweep4", 32'd1, 32'd0, 1'b0, 32'd1};
    vecs[5] = '{"sweep5", 32'd1, 32'd0, 1'b1, 32'd0};
    vecs[6] = '{"sweep6", 32'd1, 32'd2, 1'b0, 32'd1};
    vecs[7] = '{"sweep7", 32'd1, 32'd2, 1'b1, 32'd2};
    vecs[8] = '{"word_sel0", 32'hDEADBEEF, 32'h12345678, 1'b0, 32'hDEADBEEF};
    vecs[9] = '{"word_sel1", 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678};

    for (int i = 0; i < 10; i++) begin
      in1    = vecs[i].a;
      in2    = vecs[i].b;
      select = vecs[i].sel;
      #5;
      chk(vecs[i].name, out, vecs[i].exp);
    end

    // Reset with en high: registers clear, out still follows inputs.
    @(negedge clk);
    reset = 1'b1; en = 1'b1; select = 1'b0; in1 = 32'hFFFFFFFF; in2 = 32'h0;
    n_en = 1'b1; n_in1 = 5'h1F; n_select = 1'b0;
    #1;
    chk("out_before_reset_edge", out, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("reset_out_q", out_q, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_out", out, 32'hFFFFFFFF);
    chk("w5_reset_out_q", 32'(n_out_q), 32'd0);

    // Load from in2.
    @(negedge clk);
    reset = 1'b0; en = 1'b1; select = 1'b1; in2 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("load_out_q", out_q, 32'hA5A5A5A5);
    chk("load_valid", 32'(out_valid), 32'd1);
    chk("w5_load_out_q", 32'(n_out_q), 32'h1F);
    chk("w5_load_valid", 32'(n_valid), 32'd1);

    // Hold with en low while input changes.
    @(negedge clk);
    en = 1'b0; in2 = 32'h0;
    #1;
    chk("hold_out_comb", out, 32'h0);
    @(posedge clk); #1;
    chk("hold_out_q", out_q, 32'hA5A5A5A5);
    chk("hold_valid", 32'(out_valid), 32'd1);

    // Reset raised between edges has no effect until the next edge.
    reset = 1'b1; en = 1'b1; in2 = 32'h5A5A5A5A;
    #2;
    chk("reset_between_edges", out_q, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("midop_reset_out_q", out_q, 32'h0);
    chk("midop_reset_valid", 32'(out_valid), 32'd0);

    // Load from in1 after reset released; second load overwrites.
    @(negedge clk);
    reset = 1'b0; en = 1'b1; select = 1'b0; in1 = 32'h0000_1234;
    @(posedge clk); #1;
    chk("reload_in1", out_q, 32'h0000_1234);
    @(negedge clk);
    select = 1'b1; in2 = 32'h8000_0001;
    @(posedge clk); #1;
    chk("reload_in2", out_q, 32'h8000_0001);
    chk("reload_valid", 32'(out_valid), 32'd1);

    // Narrow instance combinational check.
    @(negedge clk);
    n_en = 1'b0; n_in1 = 5'h1F; n_in2 = 5'h00; n_select = 1'b0;
    #1;
    chk("w5_sel0", 32'(n_out), 32'h1F);
    n_select = 1'b1; n_in2 = 5'h0A;
    #1;
    chk("w5_sel1", 32'(n_out), 32'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux2_32.md
# mux2_32

Two-input, word-wide selector for the MIPS datapath, used wherever one of two operands is picked: ALUSrc, MemtoReg, RegDst, PC-source. A combinational output `out` gives the selected word in the same delta. A registered copy `out_q`, with a valid flag, serves pipeline-register use. One clock domain, synchronous active-high reset.

## Interface
Parameters:
- `WIDTH`, default 32: data width of `in1`, `in2`, `out` and `out_q`.

Ports:
- `clk`  input  1  rising-edge clock; used only by the registered path.
- `reset`  input  1  synchronous, active-high reset; clears registered state on the `clk` rising edge where it is high.
- `in1`  input  WIDTH  data input selected when `select`=0.
- `in2`  input  WIDTH  data input selected when `select`=1.
- `out`  output  WIDTH  combinational selection.
- `select`  input  1  0 selects `in1`, 1 selects `in2`.
- `en`  input  1  load enable for the output register.
- `out_q`  output  WIDTH  registered selection.
- `out_valid`  output  1  high once `out_q` holds data loaded since the last reset.

Declaration order is fixed as: `in1`, `in2`, `out`, `select`, `clk`, `reset`, `en`, `out_q`, `out_valid`. The first four therefore instantiate positionally as (in1, in2, out, select).

## Operation
- `out` = `select` ? `in2` : `in1`.
  - Purely combinational, bit-for-bit, with no width change.
  - Reset, `clk` and `en` have no effect on `out`.
- If `select` is X or Z, `out` is don't-care. The implementation uses a plain conditional; no X-propagation masking is required.
- Registered path, evaluated on each `clk` rising edge, in priority order:
  - `reset`=1: `out_q` ← 0, `out_valid` ← 0.
  - else `en`=1: `out_q` ← current `out`, `out_valid` ← 1.
  - else: hold both.
- There is no handshake and no back-pressure. `en` is a plain load strobe.

## Timing
- `out`: zero-cycle latency. It settles in the same simulation time step as any change on `in1`, `in2` or `select`.
- `out_q`: one-cycle latency. It reflects the inputs sampled at the edge where `en`=1.
- Reset values: `out_q`=0, `out_valid`=0. `out` has no reset value because it follows the inputs.
- Reset is synchronous. Asserting `reset` between edges changes nothing until the next rising edge.
- Simultaneous `reset`=1 and `en`=1: reset wins.
- If `reset` is asserted mid-operation, `out_q` clears at that edge even if `en` is high.
- Before the first reset edge, `out_q` and `out_valid` are X.
- Inputs changing at the same time as the edge: the pre-edge values are captured.

## Test plan
- Combinational sweep, `WIDTH`=32, all other bits 0, no clock edges. Drive {`in1[0]`, `in2[1]`, `select`} through 0..7, wait 5 time units each step. Required `out` in decimal for steps 0..7: 0, 0, 0, 2, 1, 0, 1, 2.
- Full-word select:
  - `in1`=32'hDEADBEEF, `in2`=32'h12345678, `select`=0 → `out`=32'hDEADBEEF.
  - Toggle `select` to 1 → `out`=32'h12345678 immediately.
- Reset:
  - Hold `reset`=1 across one edge with `en`=1 and `in1`=32'hFFFFFFFF → `out_q`=0, `out_valid`=0.
  - `out` still equals 32'hFFFFFFFF throughout.
- Register load:
  - After reset, `en`=1, `select`=1, `in2`=32'hA5A5A5A5, one edge → `out_q`=32'hA5A5A5A5, `out_valid`=1.
  - Then `en`=0, change `in2`=32'h0, one edge → `out_q` holds 32'hA5A5A5A5.
- Reset mid-operation: with `out_q` loaded, assert `reset`=1 for one edge → `out_q`=0, `out_valid`=0 at that edge.
- Parameter check: instantiate with `WIDTH`=5, `in1`=5'h1F, `in2`=5'h00, `select`=0 → `out`=5'h1F.
